// File: rtl/fxp8s_pkg.sv
// rtl/fxp8s_pkg.sv - shared fxp8s widths, host address layout and streamer FSM states
package fxp8s_pkg;

  localparam int FXP8S_WIDTH = 8;
  localparam int FXP8S_SIGN  = 7;
  localparam int FXP8S_BUS_W = 2 * FXP8S_WIDTH;

  localparam int HOST_ADDR_W  = 3;
  localparam int ADDR_MAT_BIT = 2;
  localparam int ADDR_ROW_BIT = 1;
  localparam int ADDR_COL_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_A,
    ST_PAD_A,
    ST_SEND_B,
    ST_PAD_B,
    ST_FIN
  } mat_state_e;

  function automatic logic [HOST_ADDR_W-1:0] elem_addr(input logic mat, input logic row,
                                                        input logic col);
    logic [HOST_ADDR_W-1:0] a;
    a = '0;
    a[ADDR_MAT_BIT] = mat;
    a[ADDR_ROW_BIT] = row;
    a[ADDR_COL_BIT] = col;
    return a;
  endfunction

endpackage

// File: rtl/fxp8s_mat_streamer.sv
// rtl/fxp8s_mat_streamer.sv - host-loaded 2x2 A/B operand store streamed row by row to the PE input
module fxp8s_mat_streamer
  import fxp8s_pkg::*;
#(
  parameter int DIM    = 2,
  parameter int ELEM_W = FXP8S_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   host_wr,
  input  logic [2:0]             host_addr,
  input  logic [ELEM_W-1:0]      host_wdata,
  input  logic                   cfg_rows_a,
  input  logic                   cfg_rows_b,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   en_in_data,
  input  logic                   rdy_in_data,
  output logic                   in_mat,
  output logic                   in_mat_done,
  output logic [2*ELEM_W-1:0]    in_data
);

  localparam int N_ELEM = 2 * DIM * DIM;

  mat_state_e state_q, state_d;
  logic       row_q, row_d;
  logic       rows_a_q, rows_a_d;
  logic       rows_b_q, rows_b_d;

  logic [ELEM_W-1:0] mem [N_ELEM];
  logic [ELEM_W-1:0] mem_nx [N_ELEM];

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                mat_q, mat_d;
  logic                md_q, md_d;
  logic [2*ELEM_W-1:0] data_q, data_d;

  logic wr_en;
  logic accept;

  assign wr_en  = host_wr & ~busy_q;
  assign accept = en_q & rdy_in_data;

  // Write-forwarded view so a write coinciding with start is seen by the first beat.
  always_comb begin
    mem_nx = mem;
    if (wr_en) mem_nx[host_addr] = host_wdata;
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    rows_a_d = rows_a_q;
    rows_b_d = rows_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rows_a_d = cfg_rows_a;
          rows_b_d = cfg_rows_b;
          row_d    = 1'b0;
          state_d  = ST_SEND_A;
        end
      end
      ST_SEND_A: begin
        if (accept) begin
          if (row_q == rows_a_q) begin
            if (rows_a_q == 1'b0) begin
              state_d = ST_PAD_A;
            end else begin
              state_d = ST_SEND_B;
              row_d   = 1'b0;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_PAD_A: begin
        state_d = ST_SEND_B;
        row_d   = 1'b0;
      end
      ST_SEND_B: begin
        if (accept) begin
          if (row_q == rows_b_q) begin
            state_d = (rows_b_q == 1'b0) ? ST_PAD_B : ST_FIN;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_PAD_B: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on clock edges.
  always_comb begin
    en_d   = 1'b0;
    md_d   = 1'b0;
    data_d = '0;
    mat_d  = mat_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_SEND_A, ST_SEND_B: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        mat_d  = (state_d == ST_SEND_B);
        data_d = {mem_nx[elem_addr(mat_d, row_d, 1'b0)], mem_nx[elem_addr(mat_d, row_d, 1'b1)]};
      end
      ST_PAD_A, ST_PAD_B: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        md_d   = 1'b1;
        mat_d  = (state_d == ST_PAD_B);
      end
      ST_FIN:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      row_q    <= 1'b0;
      rows_a_q <= 1'b0;
      rows_b_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= 1'b0;
      mat_q    <= 1'b0;
      md_q     <= 1'b0;
      data_q   <= '0;
      for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      rows_a_q <= rows_a_d;
      rows_b_q <= rows_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_q     <= en_d;
      mat_q    <= mat_d;
      md_q     <= md_d;
      data_q   <= data_d;
      if (wr_en) mem[host_addr] <= host_wdata;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign en_in_data  = en_q;
  assign in_mat      = mat_q;
  assign in_mat_done = md_q;
  assign in_data     = data_q;

endmodule

// File: doc/fxp8s_mat_streamer.md
# fxp8s_mat_streamer

Source-side driver for the fxp8s PE block input stream. Holds one 2x2 operand pair (matrix A, matrix B) of signed 8-bit fixed-point elements, loaded through a byte-wide host write port. On `start` it streams the rows of A, then the rows of B, using the `en_in_data`/`rdy_in_data` handshake with `in_mat`/`in_mat_done` framing. It sits between the host/config bus and the PE block input port.

## Interface
- `DIM`, 2, matrix dimension (rows and columns); only 2 is supported.
- `ELEM_W`, 8, element width in bits (fxp8s, sign bit 7, magnitude bits 6:0).
- `clk`  in  1  single clock, all logic on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `host_wr`  in  1  host write strobe.
- `host_addr`  in  3  element address: bit2 = matrix (0 = A, 1 = B), bit1 = row, bit0 = column.
- `host_wdata`  in  8  element value.
- `cfg_rows_a`  in  1  A row count minus 1; sampled at `start`.
- `cfg_rows_b`  in  1  B row count minus 1; sampled at `start`.
- `start`  in  1  one-cycle pulse that begins a transfer.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the pair has been sent.
- `en_in_data`  out  1  beat valid.
- `rdy_in_data`  in  1  sink ready. May depend combinationally on `en_in_data`.
- `in_mat`  out  1  0 = beat belongs to A, 1 = beat belongs to B.
- `in_mat_done`  out  1  end-of-matrix marker (pad beat).
- `in_data`  out  16  row payload: [15:8] = column 0, [7:0] = column 1.

## Operation
- Storage: 8 x 8-bit registers. `host_wr` writes `host_wdata` to `host_addr` only while not `busy`; writes while busy are dropped. Contents survive `done`. Reset clears all elements to 0.
- FSM states: IDLE, SEND_A, PAD_A, SEND_B, PAD_B, FIN.
  - IDLE: `start` latches the row counts, clears row counter `row`, and goes to SEND_A. A `start` outside IDLE is ignored.
  - SEND_A: `en_in_data`=1, `in_mat`=0, `in_data` = A[row]. Beat accepted when `en_in_data & rdy_in_data`.
    - Accepted and `row == rows_a`: go to PAD_A if `rows_a` = 0, else to SEND_B with `row` = 0.
    - Accepted otherwise: `row` + 1.
  - PAD_A: one cycle with `en_in_data`=1, `in_mat`=0, `in_mat_done`=1, `in_data`=0. Does not wait for `rdy_in_data`; the sink zero-fills the row. Then go to SEND_B with `row` = 0.
  - SEND_B / PAD_B: same as SEND_A / PAD_A with `in_mat`=1, data from B, and count `rows_b`. Exit goes to FIN.
  - FIN: `done`=1 for one cycle, `busy` drops, then IDLE.
- Outside SEND/PAD states, `en_in_data`, `in_mat_done`, and `in_data` are 0; `in_mat` holds its last value.
- All stream outputs are registered. While `en_in_data`=1 and `rdy_in_data`=0, the payload and `in_mat` stay stable.

## Timing
- Reset values: `busy`=0, `done`=0, `en_in_data`=0, `in_mat`=0, `in_mat_done`=0, `in_data`=0; FSM in IDLE.
- `start` sampled at edge t: first beat is visible from cycle t+1.
- With `rdy_in_data` held high, one beat per cycle. Full transfer (2+2 rows) has beats in cycles t+1..t+4, `done` in t+5.
- Each row count of 0 adds one pad cycle.
- Stall: a beat is held indefinitely while `rdy_in_data`=0. No timeout.
- `host_wr` in the same cycle as an accepted `start`: the write lands and the transfer uses the new value.
- `rstn` low mid-transfer: outputs go to reset values immediately. No partial-frame recovery; the sink is reset by the same `rstn`.

## Structure
- Shared package `fxp8s_pkg` holds:
  - `FXP8S_WIDTH`, `FXP8S_SIGN`, and the bus-width constant.
  - The FSM state enum.
  - The host address field positions.
- Single module. No sub-module is natural; the element store is an 8-entry register file inside the block.

## Test plan
- Load A = {1,2,3,4}, B = {5,6,7,8}, rows 2/2, `rdy` high, `start` → `in_data` 0x0102, 0x0304 (`in_mat`=0), then 0x0506, 0x0708 (`in_mat`=1) in cycles t+1..t+4; `done` at t+5.
- Same load, `rdy` low for 3 cycles on the second A beat → 0x0304 held stable for 4 cycles; no beat dropped or duplicated.
- `cfg_rows_a`=0, `cfg_rows_b`=1 → beat 0x0102, then a pad beat (`in_mat_done`=1, data 0, `in_mat`=0), then the two B beats; `done` at t+5.
- `host_wr` to A00 = 0x7F while `busy` → next transfer still sends the old A00; a write after `done` → the following transfer sends 0x7F.
- Second `start` mid-transfer → ignored; exactly one `done` pulse.
- `rstn` low during SEND_B → `en_in_data`=0 and `busy`=0 immediately; after release, a new `start` sends the full sequence with elements reset to 0.
